// File: rtl/bitcoin_result_scan.sv
// Scans NUM_NONCES result words from memory, keeps the smallest (lowest index on ties),
// compares it against the target and writes a two-word summary back before pulsing done.
module bitcoin_result_scan #(
   parameter int NUM_NONCES = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [15:0] output_addr,
   input  logic [15:0] summary_addr,
   input  logic [31:0] target,
   output logic        done,
   output logic        found,
   output logic [7:0]  best_nonce,
   output logic [31:0] best_value,
   output logic        mem_clk,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data
);

   typedef enum logic [2:0] {IDLE, READ, SCAN, WRITE0, WRITE1, DONE} state_t;

   localparam logic [7:0] LAST_IDX = 8'(NUM_NONCES - 1);

   state_t      state_reg;
   logic [7:0]  idx_reg;
   logic [15:0] summary_addr_reg;
   logic [31:0] target_reg;

   // Best value including the word arriving this cycle; found must see the last word too.
   logic        word_better;
   logic [31:0] scan_best;

   assign mem_clk     = clk;
   assign word_better = mem_read_data < best_value;
   assign scan_best   = word_better ? mem_read_data : best_value;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg        <= IDLE;
         idx_reg          <= '0;
         summary_addr_reg <= '0;
         target_reg       <= '0;
         done             <= 1'b0;
         found            <= 1'b0;
         best_nonce       <= '0;
         best_value       <= 32'hFFFF_FFFF;
         mem_we           <= 1'b0;
         mem_addr         <= '0;
         mem_write_data   <= '0;
      end else begin
         done <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  summary_addr_reg <= summary_addr;
                  target_reg       <= target;
                  mem_addr         <= output_addr;
                  mem_we           <= 1'b0;
                  idx_reg          <= '0;
                  best_value       <= 32'hFFFF_FFFF;
                  best_nonce       <= '0;
                  found            <= 1'b0;
                  state_reg        <= READ;
               end
            end
            READ: begin
               mem_addr  <= mem_addr + 16'd1;
               state_reg <= SCAN;
            end
            SCAN: begin
               if (word_better) begin
                  best_value <= mem_read_data;
                  best_nonce <= idx_reg;
               end
               mem_addr <= mem_addr + 16'd1;
               idx_reg  <= idx_reg + 8'd1;
               if (idx_reg == LAST_IDX) begin
                  found     <= scan_best < target_reg;
                  state_reg <= WRITE0;
               end
            end
            WRITE0: begin
               mem_we         <= 1'b1;
               mem_addr       <= summary_addr_reg;
               mem_write_data <= {found, 23'b0, best_nonce};
               state_reg      <= WRITE1;
            end
            WRITE1: begin
               mem_addr       <= summary_addr_reg + 16'd1;
               mem_write_data <= best_value;
               state_reg      <= DONE;
            end
            DONE: begin
               mem_we    <= 1'b0;
               done      <= 1'b1;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule
